// File: rtl/mult_acc_array_pipe_if.sv
// Operand-beat / group-result bus of the multiply-accumulate array.
//   master : operand source and result sink (fetch side + requant side)
//   slave  : the mult_acc_array_pipe datapath
// Beats:   in_valid/in_ready handshake, in_signed/in_last tags, packed lane operands.
// Results: out_valid/out_ready handshake, packed lane accumulators, sticky overflow.
interface mult_acc_array_pipe_if #(
  parameter int unsigned LANES = 576,
  parameter int unsigned A_W   = 24,
  parameter int unsigned B_W   = 16,
  parameter int unsigned ACC_W = 48
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_signed;
  logic                   in_last;
  logic [LANES*A_W-1:0]   in_a;
  logic [LANES*B_W-1:0]   in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] out_acc;
  logic                   out_ovf;

  modport master (
    output in_valid, in_signed, in_last, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_signed, in_last, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );

endinterface

// File: rtl/mult_acc_array_pipe.sv
// LANES independent A x B multipliers behind an operand register and a LAT-deep
// product pipeline, followed by per-lane accumulators that sum variable-length
// groups delimited by in_last. Each beat selects signed or unsigned arithmetic.
// One global advance signal shifts every stage; a held result stalls the pipe.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mult_acc_array_pipe_if
//                in_valid/in_ready/in_signed/in_last/in_a/in_b  (operand beats)
//                out_valid/out_ready/out_acc/out_ovf             (group results)
// ACC_W must be at least P_W+1 so a single extended product always fits.
module mult_acc_array_pipe #(
  parameter int unsigned LANES = 576,
  parameter int unsigned A_W   = 24,
  parameter int unsigned B_W   = 16,
  parameter int unsigned P_W   = A_W + B_W,
  parameter int unsigned ACC_W = 48,
  parameter int unsigned LAT   = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  mult_acc_array_pipe_if.slave bus
);

  localparam int unsigned AV_W  = LANES * A_W;
  localparam int unsigned BV_W  = LANES * B_W;
  localparam int unsigned PV_W  = LANES * P_W;
  localparam int unsigned CV_W  = LANES * ACC_W;
  localparam int unsigned EXT_W = ACC_W - P_W;

  // Exact product: one guard bit per operand carries the sign (signed beat)
  // or a zero (unsigned beat); the low P_W bits are exact in both modes.
  function automatic logic [P_W-1:0] mul_lane(input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b,
                                               input logic           sgn);
    logic signed [A_W:0]   ax;
    logic signed [B_W:0]   bx;
    logic signed [P_W+1:0] p;
    ax = $signed({sgn & a[A_W-1], a});
    bx = $signed({sgn & b[B_W-1], b});
    p  = (P_W+2)'(ax) * (P_W+2)'(bx);
    return p[P_W-1:0];
  endfunction

  // Widen a product to accumulator width according to the beat's mode.
  function automatic logic [ACC_W-1:0] ext_prod(input logic [P_W-1:0] p,
                                                 input logic           sgn);
    return {{EXT_W{sgn & p[P_W-1]}}, p};
  endfunction

  // One lane update: returns {overflow, wrapped sum}. The first beat of a group
  // loads the product directly and can never overflow.
  function automatic logic [ACC_W:0] lane_step(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] addend,
                                               input logic             sgn,
                                               input logic             start);
    logic [ACC_W:0] sum;
    logic           ovf;
    sum = {1'b0, acc} + {1'b0, addend};
    ovf = 1'b0;
    if (start) begin
      sum = {1'b0, addend};
    end else if (sgn) begin
      ovf = (addend[ACC_W-1] == acc[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      ovf = sum[ACC_W];
    end
    return {ovf, sum[ACC_W-1:0]};
  endfunction

  logic            adv_c;

  logic            op_v_q;
  logic            op_s_q;
  logic            op_l_q;
  logic [AV_W-1:0] op_a_q;
  logic [BV_W-1:0] op_b_q;

  logic [LAT-1:0]  pv_q;
  logic [LAT-1:0]  ps_q;
  logic [LAT-1:0]  pl_q;
  logic [PV_W-1:0] pp_q [LAT];

  logic [PV_W-1:0] prod_c;
  logic [CV_W-1:0] acc_nxt_c;
  logic [ACC_W:0]  step_c;
  logic            lane_ovf_c;

  logic [CV_W-1:0] acc_q;
  logic            ovf_q;
  logic            start_q;
  logic            out_valid_q;

  logic            v_lat;
  logic            s_lat;
  logic            l_lat;
  logic [PV_W-1:0] p_lat;

  // Global advance: everything moves unless a presented result is refused.
  assign adv_c        = !out_valid_q | bus.out_ready;
  assign bus.in_ready = adv_c;

  assign v_lat = pv_q[LAT-1];
  assign s_lat = ps_q[LAT-1];
  assign l_lat = pl_q[LAT-1];
  assign p_lat = pp_q[LAT-1];

  // Stage valids; bubbles travel down the pipe like beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_v_q <= 1'b0;
      pv_q   <= '0;
    end else if (adv_c) begin
      op_v_q  <= bus.in_valid;
      pv_q[0] <= op_v_q;
      for (int unsigned k = 1; k < LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
      end
    end
  end

  // Operand, tag and product stages; contents are qualified by the valids,
  // so these wide registers carry no reset.
  always_ff @(posedge clk) begin
    if (adv_c) begin
      op_a_q   <= bus.in_a;
      op_b_q   <= bus.in_b;
      op_s_q   <= bus.in_signed;
      op_l_q   <= bus.in_last;
      pp_q[0]  <= prod_c;
      ps_q[0]  <= op_s_q;
      pl_q[0]  <= op_l_q;
      for (int unsigned k = 1; k < LAT; k++) begin
        pp_q[k] <= pp_q[k-1];
        ps_q[k] <= ps_q[k-1];
        pl_q[k] <= pl_q[k-1];
      end
    end
  end

  // Lane multipliers on the registered operands.
  always_comb begin
    prod_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod_c[i*P_W +: P_W] = mul_lane(op_a_q[i*A_W +: A_W], op_b_q[i*B_W +: B_W], op_s_q);
    end
  end

  // Next accumulator values and the OR of lane overflows for the beat at stage LAT.
  always_comb begin
    acc_nxt_c  = '0;
    step_c     = '0;
    lane_ovf_c = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      step_c = lane_step(acc_q[i*ACC_W +: ACC_W],
                         ext_prod(p_lat[i*P_W +: P_W], s_lat),
                         s_lat, start_q);
      acc_nxt_c[i*ACC_W +: ACC_W] = step_c[ACC_W-1:0];
      lane_ovf_c                  = lane_ovf_c | step_c[ACC_W];
    end
  end

  // Accumulators double as the result register. A last beat raises out_valid;
  // any other advance drops it, including the advance that consumes a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      start_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (adv_c) begin
      if (v_lat) begin
        acc_q       <= acc_nxt_c;
        ovf_q       <= (start_q ? 1'b0 : ovf_q) | lane_ovf_c;
        start_q     <= l_lat;
        out_valid_q <= l_lat;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule
